// File: rtl/parallel_ram_pkg.sv
// Shared types and default sizes for the parallel_RAM two-master arbiter.
package parallel_ram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 51200;

    typedef enum logic [1:0] {
        RR   = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // One-deep read/error response record, one cycle behind acceptance.
    typedef struct packed {
        logic valid;
        logic owner;
        logic oor;
    } resp_t;

endpackage

// File: rtl/parallel_ram_rr_arb.sv
// Two-way round-robin grant with lock-based ownership; grants are combinational.
module parallel_ram_rr_arb
    import parallel_ram_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic lock0_i,
    input  logic lock1_i,
    output logic grant0_o,
    output logic grant1_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;

    // State register; last_q = 1 means m1 was granted last, so m0 wins the next conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RR;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state and last-granted tracking.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            RR: begin
                if (grant0_o) begin
                    last_d  = 1'b0;
                    state_d = lock0_i ? OWN0 : RR;
                end else if (grant1_o) begin
                    last_d  = 1'b1;
                    state_d = lock1_i ? OWN1 : RR;
                end else begin
                    state_d = RR;
                end
            end
            OWN0: begin
                if (!req0_i || !lock0_i) begin
                    state_d = RR;
                    last_d  = 1'b0;
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                if (!req1_i || !lock1_i) begin
                    state_d = RR;
                    last_d  = 1'b1;
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d = RR;
                last_d  = 1'b1;
            end
        endcase
    end

    // Grant decode; the owner alone may be granted while locked.
    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (reset) begin
            grant0_o = 1'b0;
            grant1_o = 1'b0;
        end else begin
            case (state_q)
                RR: begin
                    if (req0_i && req1_i) begin
                        grant0_o = last_q;
                        grant1_o = ~last_q;
                    end else begin
                        grant0_o = req0_i;
                        grant1_o = req1_i;
                    end
                end
                OWN0:    grant0_o = req0_i;
                OWN1:    grant1_o = req1_i;
                default: grant0_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/parallel_ram_arbiter.sv
// Shares the single-port parallel_RAM between two Avalon-MM pipelined masters,
// with round-robin/lock arbitration, range protection and a one-deep response stage.
module parallel_ram_arbiter
    import parallel_ram_pkg::*;
#(
    parameter int ADDR_W = parallel_ram_pkg::ADDR_W,
    parameter int DATA_W = parallel_ram_pkg::DATA_W,
    parameter int DEPTH  = parallel_ram_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,

    output logic                  err_oor
);

    logic              req0_s, req1_s;
    logic              grant0_s, grant1_s, any_grant_s;
    logic              sel_write_s, in_range_s;
    logic [ADDR_W-1:0] sel_addr_s;
    resp_t             resp_q, resp_d;
    logic              oor_q, oor_d;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    parallel_ram_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req0_i   (req0_s),
        .req1_i   (req1_s),
        .lock0_i  (m0_lock),
        .lock1_i  (m1_lock),
        .grant0_o (grant0_s),
        .grant1_o (grant1_s)
    );

    assign any_grant_s = grant0_s | grant1_s;
    assign sel_addr_s  = grant1_s ? m1_address : m0_address;
    assign sel_write_s = grant1_s ? m1_write   : m0_write;
    assign in_range_s  = (32'(sel_addr_s) < 32'(DEPTH));

    assign m0_waitrequest = ~grant0_s | reset;
    assign m1_waitrequest = ~grant1_s | reset;

    assign ram_address    = sel_addr_s;
    assign ram_byteenable = grant1_s ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = grant1_s ? m1_writedata  : m0_writedata;
    assign ram_chipselect = any_grant_s & in_range_s;
    assign ram_write      = any_grant_s & sel_write_s & in_range_s;
    assign ram_clken      = ~reset;

    // Capture who is owed a read response and whether the accepted access was out of range.
    always_comb begin
        resp_d = '0;
        oor_d  = 1'b0;
        if (any_grant_s) begin
            oor_d = ~in_range_s;
            if (!sel_write_s) begin
                resp_d.valid = 1'b1;
                resp_d.owner = grant1_s;
                resp_d.oor   = ~in_range_s;
            end else begin
                resp_d = '0;
            end
        end else begin
            oor_d = 1'b0;
        end
    end

    // Response register; an asynchronous reset drops any pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q <= '0;
            oor_q  <= 1'b0;
        end else begin
            resp_q <= resp_d;
            oor_q  <= oor_d;
        end
    end

    assign m0_readdatavalid = resp_q.valid & ~resp_q.owner;
    assign m1_readdatavalid = resp_q.valid &  resp_q.owner;
    assign m0_readdata      = (m0_readdatavalid & ~resp_q.oor) ? ram_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid & ~resp_q.oor) ? ram_readdata : '0;
    assign err_oor          = oor_q;

endmodule

// File: tb/tb_parallel_ram_arbiter.sv
// Directed vector table plus randomized traffic against a behavioural model of the arbiter and RAM.
module tb_parallel_ram_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int BW      = 4;
    localparam int DEPTH_T = 51200;

    typedef struct packed {
        logic [1:0]          r;
        logic [1:0]          w;
        logic [1:0]          l;
        logic [1:0][AW-1:0]  a;
        logic [1:0][BW-1:0]  be;
        logic [1:0][DW-1:0]  wd;
    } stim_t;

    typedef struct {
        stim_t        s;
        bit           rst;
        bit           ew0, ew1, ecs, erdv0, erdv1, eoor;
        logic [DW-1:0] erd0, erd1;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic [DW-1:0] ram_writedata, ram_readdata;
    logic          ram_chipselect, ram_write, ram_clken, err_oor;

    always #5 clk = ~clk;

    parallel_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .err_oor(err_oor)
    );

    // Single-port RAM: byte-enabled write, registered read data.
    bit   [DW-1:0] ram_mem [0:DEPTH_T-1];
    logic [DW-1:0] ram_q;
    assign ram_readdata = ram_q;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect && ram_address < AW'(DEPTH_T)) begin
            if (ram_write) begin
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: owner -1 means free round-robin; last is the master served last.
    logic [DW-1:0] ref_mem [int];
    int            m_owner, m_last, m_pown;
    bit            m_pv, m_eoor;
    logic [DW-1:0] m_pdata;

    function automatic logic [DW-1:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic int pick(stim_t s);
        bit q0, q1;
        q0 = s.r[0] | s.w[0];
        q1 = s.r[1] | s.w[1];
        if (m_owner >= 0) return ((m_owner == 0) ? q0 : q1) ? m_owner : -1;
        if (q0 && q1) return 1 - m_last;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic update(vec_t v, int g, bit inr);
        logic [DW-1:0] cur;
        int            a;
        if (v.rst) begin
            m_owner = -1; m_last = 1; m_pv = 0; m_eoor = 0;
            return;
        end
        m_pv = 0;
        m_eoor = 0;
        if (g >= 0) begin
            a = int'(v.s.a[g]);
            m_eoor = !inr;
            if (v.s.w[g]) begin
                if (inr) begin
                    cur = ref_rd(a);
                    for (int b = 0; b < BW; b++)
                        if (v.s.be[g][b]) cur[8*b +: 8] = v.s.wd[g][8*b +: 8];
                    ref_mem[a] = cur;
                end
            end else begin
                m_pv = 1; m_pown = g;
                m_pdata = inr ? ref_rd(a) : '0;
            end
        end
        if (m_owner >= 0) begin
            if (g != m_owner || !v.s.l[g]) begin
                m_last = m_owner; m_owner = -1;
            end
        end else if (g >= 0) begin
            m_last = g;
            if (v.s.l[g]) m_owner = g;
        end
    endtask

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(stim_t s);
        m0_read = s.r[0]; m0_write = s.w[0]; m0_lock = s.l[0];
        m0_address = s.a[0]; m0_byteenable = s.be[0]; m0_writedata = s.wd[0];
        m1_read = s.r[1]; m1_write = s.w[1]; m1_lock = s.l[1];
        m1_address = s.a[1]; m1_byteenable = s.be[1]; m1_writedata = s.wd[1];
    endtask

    // One cycle: drive after the edge, sample mid-cycle, advance the model at the edge.
    task automatic step(vec_t v, bit use_exp);
        int g;
        bit inr, rdv0, rdv1;
        apply(v.s);
        reset = v.rst;
        #4;
        g    = v.rst ? -1 : pick(v.s);
        inr  = (g >= 0) && (int'(v.s.a[g]) < DEPTH_T);
        rdv0 = !v.rst && m_pv && m_pown == 0;
        rdv1 = !v.rst && m_pv && m_pown == 1;
        chk("wait0", m0_waitrequest, (g != 0));
        chk("wait1", m1_waitrequest, (g != 1));
        chk("chipselect", ram_chipselect, inr);
        chk("ram_write", ram_write, inr && v.s.w[g]);
        chk("clken", ram_clken, !v.rst);
        chk("rdv0", m0_readdatavalid, rdv0);
        chk("rdv1", m1_readdatavalid, rdv1);
        chk("rdata0", m0_readdata, rdv0 ? m_pdata : '0);
        chk("rdata1", m1_readdata, rdv1 ? m_pdata : '0);
        chk("err_oor", err_oor, !v.rst && m_eoor);
        if (use_exp) begin
            chk("tbl_wait0", m0_waitrequest, v.ew0);
            chk("tbl_wait1", m1_waitrequest, v.ew1);
            chk("tbl_cs", ram_chipselect, v.ecs);
            chk("tbl_rdv0", m0_readdatavalid, v.erdv0);
            chk("tbl_rdv1", m1_readdatavalid, v.erdv1);
            chk("tbl_rd0", m0_readdata, v.erd0);
            chk("tbl_rd1", m1_readdata, v.erd1);
            chk("tbl_oor", err_oor, v.eoor);
        end
        @(posedge clk);
        update(v, g, inr);
        #1;
    endtask

    function automatic stim_t rd(stim_t b, int m, int a, bit l);
        stim_t s = b;
        s.r[m] = 1'b1; s.w[m] = 1'b0; s.l[m] = l; s.a[m] = AW'(a);
        return s;
    endfunction

    function automatic stim_t wr(stim_t b, int m, int a, logic [DW-1:0] d, logic [BW-1:0] be, bit l);
        stim_t s = b;
        s.r[m] = 1'b0; s.w[m] = 1'b1; s.l[m] = l; s.a[m] = AW'(a); s.wd[m] = d; s.be[m] = be;
        return s;
    endfunction

    function automatic vec_t vx(stim_t s, bit rst, bit ew0, bit ew1, bit ecs, bit erdv0, bit erdv1,
                                logic [DW-1:0] erd0, logic [DW-1:0] erd1, bit eoor);
        vec_t v;
        v.s = s; v.rst = rst; v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs;
        v.erdv0 = erdv0; v.erdv1 = erdv1; v.erd0 = erd0; v.erd1 = erd1; v.eoor = eoor;
        return v;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int k, as;
        s = '0;
        for (int m = 0; m < 2; m++) begin
            k = $urandom_range(0, 4);
            s.r[m] = (k == 1 || k == 3);
            s.w[m] = (k == 2 || k == 3);
            s.l[m] = ($urandom_range(0, 3) == 0);
            as = $urandom_range(0, 9);
            s.a[m] = (as < 8) ? AW'($urandom_range(0, 15)) :
                     (as == 8) ? AW'($urandom_range(51198, 51201)) : 16'hFFFF;
            s.be[m] = BW'($urandom_range(0, 15));
            s.wd[m] = $urandom;
        end
        return s;
    endfunction

    vec_t  tbl [28];
    vec_t  rv;
    stim_t idl, both;

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        m_owner = -1; m_last = 1; m_pv = 0; m_eoor = 0; m_pown = 0; m_pdata = '0;
        idl  = '0;
        both = rd(rd(idl, 0, 5, 1'b0), 1, 7, 1'b0);
        apply(idl);

        tbl[0]  = vx(wr(idl, 0, 5, 32'hDEADBEEF, 4'hF, 1'b0), 0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[1]  = vx(rd(idl, 0, 5, 1'b0),                     0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[2]  = vx(idl,                                     0, 1,1,0, 1,0, 32'hDEADBEEF, 32'h0, 0);
        tbl[3]  = vx(wr(idl, 0, 7, 32'hAABBCCDD, 4'hF, 1'b0), 0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[4]  = vx(wr(idl, 0, 7, 32'h11223344, 4'h3, 1'b0), 0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[5]  = vx(rd(idl, 0, 7, 1'b0),                     0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[6]  = vx(both, 0, 1,0,1, 1,0, 32'hAABB3344, 32'h0, 0);
        tbl[7]  = vx(both, 0, 0,1,1, 0,1, 32'h0, 32'hAABB3344, 0);
        tbl[8]  = vx(both, 0, 1,0,1, 1,0, 32'hDEADBEEF, 32'h0, 0);
        tbl[9]  = vx(both, 0, 0,1,1, 0,1, 32'h0, 32'hAABB3344, 0);
        tbl[10] = vx(rd(idl, 0, 51200, 1'b0),                 0, 0,1,0, 1,0, 32'hDEADBEEF, 32'h0, 0);
        tbl[11] = vx(wr(idl, 0, 60000, 32'h12345678, 4'hF, 1'b0), 0, 0,1,0, 1,0, 32'h0, 32'h0, 1);
        tbl[12] = vx(idl,                                     0, 1,1,0, 0,0, 32'h0, 32'h0, 1);
        tbl[13] = vx(wr(wr(idl, 0, 10, 32'h55, 4'hF, 1'b0), 1, 20, 32'd100, 4'hF, 1'b1), 0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[14] = vx(wr(wr(idl, 0, 10, 32'h55, 4'hF, 1'b0), 1, 21, 32'd101, 4'hF, 1'b1), 0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[15] = vx(wr(wr(idl, 0, 10, 32'h55, 4'hF, 1'b0), 1, 22, 32'd102, 4'hF, 1'b1), 0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[16] = vx(wr(wr(idl, 0, 10, 32'h55, 4'hF, 1'b0), 1, 23, 32'd103, 4'hF, 1'b0), 0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[17] = vx(rd(wr(idl, 0, 10, 32'h55, 4'hF, 1'b0), 1, 20, 1'b0), 0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[18] = vx(rd(idl, 1, 20, 1'b0),                    0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[19] = vx(idl,                                     0, 1,1,0, 0,1, 32'h0, 32'd100, 0);
        tbl[20] = vx(rd(rd(idl, 0, 10, 1'b1), 1, 20, 1'b0),   0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[21] = vx(rd(idl, 1, 20, 1'b0),                    0, 1,1,0, 1,0, 32'h55, 32'h0, 0);
        tbl[22] = vx(rd(idl, 1, 20, 1'b0),                    0, 1,0,1, 0,0, 32'h0, 32'h0, 0);
        tbl[23] = vx(idl,                                     0, 1,1,0, 0,1, 32'h0, 32'd100, 0);
        // Reset lands the cycle after a read is accepted: the response is dropped.
        tbl[24] = vx(rd(idl, 0, 5, 1'b0),                     0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[25] = vx(rd(idl, 0, 5, 1'b0),                     1, 1,1,0, 0,0, 32'h0, 32'h0, 0);
        tbl[26] = vx(both,                                    0, 0,1,1, 0,0, 32'h0, 32'h0, 0);
        tbl[27] = vx(idl,                                     0, 1,1,0, 1,0, 32'hDEADBEEF, 32'h0, 0);

        @(posedge clk);
        #1;
        rv = vx(idl, 1, 1,1,0, 0,0, 32'h0, 32'h0, 0);
        step(rv, 1'b1);
        step(rv, 1'b1);

        for (int i = 0; i < 28; i++) step(tbl[i], 1'b1);

        for (int c = 0; c < 800; c++) begin
            rv.s   = rand_stim();
            rv.rst = ($urandom_range(0, 79) == 0);
            step(rv, 1'b0);
        end
        rv = vx(idl, 0, 1,1,0, 0,0, 32'h0, 32'h0, 0);
        step(rv, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
